alu_operand_sequencer: RTL and testbench
========================================

Name: alu_operand_sequencer

Overview:
- Front-end control stage for the lab ALU. Loads operand A, operand B and the 4-bit operation select from board switches, one debounced button press per item.
- Drives the operands and select into the arithmetic units and the result multiplexer.
- Captures the multiplexer output and the adder carry into a result register, and derives status flags for display.
- Sits directly upstream of the result multiplexer and also consumes its output.

Parameters:
- ANCHO, 3, MSB index of the data path; data width is ANCHO+1. Must be >= 3.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles needed before the filtered button level changes. The board build overrides it with 500000.

Ports:
- reloj  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- interruptores  in  ANCHO+1  data switches.
- boton  in  1  advance button, active high, asynchronous to reloj.
- resultado  in  ANCHO+1  result multiplexer output.
- acarreo  in  1  carry/borrow from the adder/subtractor.
- operandoA  out  ANCHO+1  registered operand A.
- operandoB  out  ANCHO+1  registered operand B.
- seleccion  out  4  registered operation select.
- resultado_reg  out  ANCHO+1  captured result.
- bandera_cero  out  1  zero flag.
- bandera_negativo  out  1  negative flag.
- bandera_acarreo  out  1  carry flag.
- bandera_error  out  1  error flag: invalid opcode, or divide/modulo by zero.
- valido  out  1  result registers hold a fresh result.
- estado  out  3  current FSM state, drives LEDs.

Behaviour:
- Reset (asserted at any time, takes effect immediately):
  - All outputs go to 0 and the FSM goes to CARGA_A.
  - Synchroniser, debounce counter, filtered level and edge register all clear.
  - A reset mid-sequence discards any partially loaded operands.
- Button conditioning:
  - boton passes through a 2-flop synchroniser.
  - The filtered level toggles once the synchronised value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle clears the counter.
  - A rising edge of the filtered level produces a one-cycle pulsador pulse, issued in the cycle after the filtered level rises.
  - A button held across reset release yields exactly one pulse.
- FSM encoding: CARGA_A=0, CARGA_B=1, CARGA_OP=2, EJECUTA=3, MUESTRA=4. Unused codes go to CARGA_A on the next clock.
- Transitions:
  - CARGA_A + pulsador: operandoA <= interruptores; go to CARGA_B.
  - CARGA_B + pulsador: operandoB <= interruptores; go to CARGA_OP.
  - CARGA_OP + pulsador: seleccion <= interruptores[3:0]; go to EJECUTA.
  - EJECUTA: lasts exactly 1 cycle, no pulsador needed. Operands and select have been stable for at least 1 cycle, so resultado is valid. Capture the result registers (see below), set valido=1, go to MUESTRA.
  - MUESTRA + pulsador: valido <= 0; go to CARGA_A.
- Registers keep their values across the loop:
  - operandoA, operandoB and seleccion hold until overwritten in their own load state.
  - resultado_reg and all flags hold until the next EJECUTA.
- A pulsador arriving in EJECUTA is dropped. Only one state advance is allowed per pulse.
- Capture in EJECUTA:
  - bandera_error = 1 if seleccion > 4'b1001, or if seleccion is 0011 or 0100 with operandoB == 0.
  - If error: resultado_reg <= 0. Otherwise resultado_reg <= resultado.
  - bandera_cero = 1 when the captured value == 0, including error cases.
  - bandera_negativo = captured value [ANCHO].
  - bandera_acarreo = acarreo when seleccion is 0000 or 0001; otherwise 0.
- Output latency: a load becomes visible on its output the cycle after the pulse. Result and flags become visible the cycle after EJECUTA.

Test Plan:
- Reset, then load A=0101, B=0011, op=0000. The bench drives resultado = 4-bit A+B and acarreo = carry out. Required: resultado_reg=1000, bandera_negativo=1, bandera_cero=0, bandera_acarreo=0, bandera_error=0, valido=1, estado=4.
- Bounce: toggle boton every cycle for 20 cycles, then hold low. Required: estado stays 0 and operandoA stays 0. A clean press held for DEBOUNCE_CYCLES+3 cycles then advances estado to 1 with exactly one state change.
- Divide by zero: A=0111, B=0000, op=0011. Required: bandera_error=1, resultado_reg=0000, bandera_cero=1, valido=1.
- Invalid op: A=0001, B=0001, op=1111. Required: bandera_error=1, resultado_reg=0, bandera_acarreo=0.
- Async reset mid-load: after the A and B loads, with estado=2, pulse reset_n low between clock edges. Required: all outputs read 0 and estado=0 before the next rising edge. The following press loads operandoA.
- Subtract to zero, then re-run: A=0011, B=0011, op=0001, with the bench driving acarreo=1. Required: resultado_reg=0, bandera_cero=1, bandera_acarreo=1. The press in MUESTRA sets valido=0 and estado=0 while operandoA stays 0011.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// Lab ALU front end: debounced button steps an FSM that loads A, B and the op select from switches.
// Loads show the cycle after the pulse; result/flags the cycle after EJECUTA. No backpressure: pulses in EJECUTA are dropped.
module alu_operand_sequencer #(
  parameter int ANCHO           = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             reloj,
  input  logic             reset_n,
  input  logic [ANCHO:0]   interruptores,
  input  logic             boton,
  input  logic [ANCHO:0]   resultado,
  input  logic             acarreo,
  output logic [ANCHO:0]   operandoA,
  output logic [ANCHO:0]   operandoB,
  output logic [3:0]       seleccion,
  output logic [ANCHO:0]   resultado_reg,
  output logic             bandera_cero,
  output logic             bandera_negativo,
  output logic             bandera_acarreo,
  output logic             bandera_error,
  output logic             valido,
  output logic [2:0]       estado
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {
    CARGA_A  = 3'd0,
    CARGA_B  = 3'd1,
    CARGA_OP = 3'd2,
    EJECUTA  = 3'd3,
    MUESTRA  = 3'd4
  } estado_t;

  // ---------------- button conditioning ----------------
  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_q;
  logic          pulsador_q, pulsador_d;

  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      filt_q     <= 1'b0;
      cnt_q      <= '0;
      prev_q     <= 1'b0;
      pulsador_q <= 1'b0;
    end else begin
      sync1_q    <= boton;
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      cnt_q      <= cnt_d;
      prev_q     <= filt_q;
      pulsador_q <= pulsador_d;
    end
  end

  // Filtered level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q + CW'(1) == CNT_MAX) begin
        filt_d = ~filt_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    pulsador_d = filt_q & ~prev_q;
  end

  // ---------------- sequencing FSM ----------------
  estado_t state_q, state_d;

  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) state_q <= CARGA_A;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CARGA_A:  if (pulsador_q) state_d = CARGA_B;
      CARGA_B:  if (pulsador_q) state_d = CARGA_OP;
      CARGA_OP: if (pulsador_q) state_d = EJECUTA;
      EJECUTA:                  state_d = MUESTRA;
      MUESTRA:  if (pulsador_q) state_d = CARGA_A;
      default:                  state_d = CARGA_A;
    endcase
  end

  // ---------------- operand / result registers ----------------
  logic [ANCHO:0] op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
  logic [3:0]     sel_q, sel_d;
  logic           cero_q, cero_d, neg_q, neg_d, carry_q, carry_d, err_q, err_d;
  logic           valido_q, valido_d;
  logic           err_c;
  logic [ANCHO:0] capt_c;

  always_comb begin
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    sel_d    = sel_q;
    res_d    = res_q;
    cero_d   = cero_q;
    neg_d    = neg_q;
    carry_d  = carry_q;
    err_d    = err_q;
    valido_d = valido_q;

    err_c  = (sel_q > 4'b1001) ||
             (((sel_q == 4'b0011) || (sel_q == 4'b0100)) && (op_b_q == '0));
    capt_c = err_c ? '0 : resultado;

    case (state_q)
      CARGA_A:  if (pulsador_q) op_a_d = interruptores;
      CARGA_B:  if (pulsador_q) op_b_d = interruptores;
      CARGA_OP: if (pulsador_q) sel_d  = interruptores[3:0];
      EJECUTA: begin
        res_d    = capt_c;
        err_d    = err_c;
        cero_d   = (capt_c == '0);
        neg_d    = capt_c[ANCHO];
        carry_d  = ((sel_q == 4'b0000) || (sel_q == 4'b0001)) ? acarreo : 1'b0;
        valido_d = 1'b1;
      end
      MUESTRA:  if (pulsador_q) valido_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      sel_q    <= '0;
      res_q    <= '0;
      cero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
      valido_q <= 1'b0;
    end else begin
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      sel_q    <= sel_d;
      res_q    <= res_d;
      cero_q   <= cero_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
      valido_q <= valido_d;
    end
  end

  assign operandoA        = op_a_q;
  assign operandoB        = op_b_q;
  assign seleccion        = sel_q;
  assign resultado_reg    = res_q;
  assign bandera_cero     = cero_q;
  assign bandera_negativo = neg_q;
  assign bandera_acarreo  = carry_q;
  assign bandera_error    = err_q;
  assign valido           = valido_q;
  assign estado           = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: vector table, hand-written corner sequences, randomized runs vs. a model.
module tb_alu_operand_sequencer;

  localparam int D = 4;

  logic       reloj = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] interruptores = '0;
  logic       boton = 1'b0;
  logic [3:0] resultado = '0;
  logic       acarreo = 1'b0;
  logic [3:0] operandoA, operandoB, seleccion, resultado_reg;
  logic       bandera_cero, bandera_negativo, bandera_acarreo, bandera_error, valido;
  logic [2:0] estado;

  int pass_cnt = 0;
  int total_cnt = 0;

  alu_operand_sequencer #(.ANCHO(3), .DEBOUNCE_CYCLES(D)) dut (
    .reloj(reloj), .reset_n(reset_n), .interruptores(interruptores), .boton(boton),
    .resultado(resultado), .acarreo(acarreo), .operandoA(operandoA), .operandoB(operandoB),
    .seleccion(seleccion), .resultado_reg(resultado_reg), .bandera_cero(bandera_cero),
    .bandera_negativo(bandera_negativo), .bandera_acarreo(bandera_acarreo),
    .bandera_error(bandera_error), .valido(valido), .estado(estado)
  );

  always #5 reloj = ~reloj;

  typedef struct {
    logic [3:0] a, b, op, res;
    logic       car;
    logic [3:0] e_res;
    logic       e_z, e_n, e_c, e_e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Clean press long enough to debounce both edges; leaves the bench at a negedge.
  task automatic press(input logic [3:0] sw);
    @(negedge reloj);
    interruptores = sw;
    boton = 1'b1;
    repeat (D + 3) @(negedge reloj);
    boton = 1'b0;
    repeat (D + 6) @(negedge reloj);
  endtask

  task automatic do_reset();
    @(negedge reloj);
    reset_n = 1'b0;
    repeat (2) @(negedge reloj);
    reset_n = 1'b1;
    @(negedge reloj);
  endtask

  // Environment stand-in for the arithmetic units and result mux.
  function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    case (op)
      4'd0: return {1'b0, a} + {1'b0, b};
      4'd1: return {1'b0, a} - {1'b0, b};
      4'd2: return {1'b0, a & b};
      4'd3: return (b == 0) ? 5'd0 : {1'b0, a / b};
      4'd4: return (b == 0) ? 5'd0 : {1'b0, a % b};
      4'd5: return {1'b0, a | b};
      4'd6: return {1'b0, a ^ b};
      4'd7: return {1'b0, ~a};
      4'd8: return {1'b0, a << 1};
      4'd9: return {1'b0, a >> 1};
      default: return 5'h1A;
    endcase
  endfunction

  task automatic run_and_check(input string tag, input vec_t v);
    resultado = v.res;
    acarreo   = v.car;
    press(v.a);
    chk({tag, " opA"}, operandoA, v.a);
    chk({tag, " estado_b"}, estado, 3'd1);
    press(v.b);
    chk({tag, " opB"}, operandoB, v.b);
    press(v.op);
    chk({tag, " sel"}, seleccion, v.op);
    chk({tag, " estado"}, estado, 3'd4);
    chk({tag, " valido"}, valido, 1'b1);
    chk({tag, " res"}, resultado_reg, v.e_res);
    chk({tag, " cero"}, bandera_cero, v.e_z);
    chk({tag, " neg"}, bandera_negativo, v.e_n);
    chk({tag, " carry"}, bandera_acarreo, v.e_c);
    chk({tag, " err"}, bandera_error, v.e_e);
  endtask

  vec_t vt[$];

  initial begin
    vec_t v;
    int changes;
    logic [2:0] last;

    //       a      b      op     res    car   e_res  z  n  c  e
    vt.push_back('{4'h5, 4'h3, 4'h0, 4'h8, 1'b0, 4'h8, 0, 1, 0, 0});
    vt.push_back('{4'h7, 4'h0, 4'h3, 4'hF, 1'b0, 4'h0, 1, 0, 0, 1});
    vt.push_back('{4'h1, 4'h1, 4'hF, 4'h2, 1'b1, 4'h0, 1, 0, 0, 1});
    vt.push_back('{4'h9, 4'h0, 4'h4, 4'h9, 1'b0, 4'h0, 1, 0, 0, 1});
    vt.push_back('{4'h6, 4'h2, 4'h3, 4'h3, 1'b1, 4'h3, 0, 0, 0, 0});
    vt.push_back('{4'hF, 4'h1, 4'h0, 4'h0, 1'b1, 4'h0, 1, 0, 1, 0});
    vt.push_back('{4'h8, 4'h1, 4'h9, 4'h4, 1'b1, 4'h4, 0, 0, 0, 0});
    vt.push_back('{4'h8, 4'h1, 4'hA, 4'h4, 1'b0, 4'h0, 1, 0, 0, 1});
    vt.push_back('{4'hC, 4'hA, 4'h2, 4'h8, 1'b1, 4'h8, 0, 1, 0, 0});

    repeat (2) @(negedge reloj);
    chk("reset estado", estado, 3'd0);
    chk("reset opA", operandoA, 4'h0);
    chk("reset valido", valido, 1'b0);
    chk("reset flags", {bandera_cero, bandera_negativo, bandera_acarreo, bandera_error}, 4'h0);
    reset_n = 1'b1;
    @(negedge reloj);

    // Bounce must never advance the FSM.
    for (int i = 0; i < 20; i++) begin
      interruptores = 4'hA;
      boton = ~boton;
      @(negedge reloj);
    end
    boton = 1'b0;
    repeat (2 * D + 4) @(negedge reloj);
    chk("bounce estado", estado, 3'd0);
    chk("bounce opA", operandoA, 4'h0);

    // Clean press: exactly one state change.
    changes = 0;
    last = estado;
    interruptores = 4'h3;
    boton = 1'b1;
    for (int i = 0; i < 3 * D + 12; i++) begin
      if (i == D + 3) boton = 1'b0;
      @(negedge reloj);
      if (estado !== last) changes++;
      last = estado;
    end
    chk("clean estado", estado, 3'd1);
    chk("clean changes", changes, 1);
    chk("clean opA", operandoA, 4'h3);
    do_reset();

    foreach (vt[i]) begin
      run_and_check($sformatf("vec%0d", i), vt[i]);
      press(4'h0);
      chk($sformatf("vec%0d back", i), estado, 3'd0);
      chk($sformatf("vec%0d valido0", i), valido, 1'b0);
      chk($sformatf("vec%0d keepA", i), operandoA, vt[i].a);
      chk($sformatf("vec%0d keepres", i), resultado_reg, vt[i].e_res);
    end

    // Async reset while in CARGA_OP, checked before the next rising edge.
    press(4'h6);
    press(4'h5);
    chk("midload estado", estado, 3'd2);
    @(negedge reloj);
    #1 reset_n = 1'b0;
    #2;
    chk("arst estado", estado, 3'd0);
    chk("arst opA", operandoA, 4'h0);
    chk("arst opB", operandoB, 4'h0);
    chk("arst res", resultado_reg, 4'h0);
    chk("arst misc", {seleccion, bandera_cero, bandera_negativo, bandera_acarreo, bandera_error, valido}, 9'h0);
    reset_n = 1'b1;
    press(4'h9);
    chk("after arst opA", operandoA, 4'h9);
    chk("after arst estado", estado, 3'd1);
    do_reset();

    // Randomized sequences against the model.
    for (int n = 0; n < 24; n++) begin
      logic [4:0] r;
      v.a  = 4'($urandom);
      v.b  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      v.op = 4'($urandom_range(0, 15));
      r = alu_model(v.a, v.b, v.op);
      v.res = r[3:0];
      v.car = r[4];
      v.e_e = (v.op > 4'd9) || ((v.op == 4'd3 || v.op == 4'd4) && v.b == 4'd0);
      v.e_res = v.e_e ? 4'h0 : v.res;
      v.e_z = (v.e_res == 4'h0);
      v.e_n = v.e_res[3];
      v.e_c = (v.op <= 4'd1) ? v.car : 1'b0;
      run_and_check($sformatf("rnd%0d", n), v);
      press(4'h0);
      chk($sformatf("rnd%0d back", n), {estado, valido}, 4'h0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
